// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer (F, R, X, M, W) with memory handshake,
// memory-wait timeout, halt handling and a retired-instruction counter.
module phase_sequencer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        run,
  input  logic        halt_req,
  input  logic        mem_acc_m,
  input  logic        mem_ack,
  output logic [4:0]  phase,
  output logic        mem_req,
  output logic        running,
  output logic        halted,
  output logic        err,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED,
    ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    PH_F,
    PH_R,
    PH_X,
    PH_M,
    PH_W
  } ph_t;

  state_t      state_q, state_d;
  ph_t         ph_q, ph_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] retired_q, retired_d;

  // State, phase, wait counter and retired counter registers (sync active-low reset)
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      ph_q      <= PH_F;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, phase sequencing, memory request and wait/timeout logic.
  // The wait counter defaults to clear, so it only survives a cycle that is
  // an un-acknowledged memory wait; this covers both "cleared on advance" and
  // "cleared while mem_req=0".
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    wait_d    = '0;
    retired_d = retired_q;
    mem_req   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
          ph_d    = PH_F;
        end
      end

      ST_RUN: begin
        unique case (ph_q)
          PH_F: begin
            mem_req = 1'b1;
            if (mem_ack)              ph_d    = PH_R;
            else if (wait_q == 8'hFF) state_d = ST_ERROR;
            else                      wait_d  = wait_q + 8'd1;
          end
          PH_R: ph_d = PH_X;
          PH_X: ph_d = PH_M;
          PH_M: begin
            if (mem_acc_m) begin
              mem_req = 1'b1;
              if (mem_ack)              ph_d    = PH_W;
              else if (wait_q == 8'hFF) state_d = ST_ERROR;
              else                      wait_d  = wait_q + 8'd1;
            end else begin
              ph_d = PH_W;
            end
          end
          PH_W: begin
            retired_d = retired_q + 32'd1;
            ph_d      = PH_F;
            if (halt_req)  state_d = ST_HALTED;
            else if (!run) state_d = ST_IDLE;
          end
          default: ph_d = PH_F;
        endcase
      end

      ST_HALTED: begin
        if (!run) state_d = ST_IDLE;
      end

      ST_ERROR: state_d = ST_ERROR;

      default: state_d = ST_IDLE;
    endcase
  end

  // One-hot phase decode and status flags from the registered state
  always_comb begin
    phase = '0;
    if (state_q == ST_RUN) begin
      unique case (ph_q)
        PH_F:    phase = 5'b00001;
        PH_R:    phase = 5'b00010;
        PH_X:    phase = 5'b00100;
        PH_M:    phase = 5'b01000;
        PH_W:    phase = 5'b10000;
        default: phase = '0;
      endcase
    end
    running = (state_q == ST_RUN);
    halted  = (state_q == ST_HALTED);
    err     = (state_q == ST_ERROR);
    retired = retired_q;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL provide port: clk  input  1  rising-edge clock.
REQ-002 SHALL provide port: n_rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide port: run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary.
REQ-004 SHALL provide port: halt_req  input  1  decoder flag; current instruction is a halt; sampled only in W.
REQ-005 SHALL provide port: mem_acc_m  input  1  current instruction accesses memory in M; sampled only in M.
REQ-006 SHALL provide port: mem_ack  input  1  memory completion strobe; ignored while mem_req=0.
REQ-007 SHALL provide port: phase  output  5  one-hot phase; bit0=F, bit1=R, bit2=X, bit3=M, bit4=W; all-zero when not running.
REQ-008 SHALL provide port: mem_req  output  1  combinational memory request.
REQ-009 SHALL provide port: running  output  1  1 in RUN state.
REQ-010 SHALL provide port: halted  output  1  1 in HALTED state.
REQ-011 SHALL provide port: err  output  1  1 in ERROR state (memory timeout).
REQ-012 SHALL provide port: retired  output  32  count of completed W phases.

Function
REQ-013 SHALL implement states IDLE, RUN, HALTED, ERROR; phase is non-zero only in RUN and is always exactly one-hot there.
REQ-014 IDLE: phase=0; if run=1 at a clock edge, next cycle state=RUN, phase=F.
REQ-015 F: mem_req=1; advance to R on the edge where mem_ack=1; otherwise hold F.
REQ-016 R and X: advance unconditionally after one cycle (R->X->M).
REQ-017 M: if mem_acc_m=1, mem_req=1 and hold M until mem_ack=1, then advance to W; if mem_acc_m=0, mem_req=0 and advance to W after one cycle.
REQ-018 W: lasts exactly one cycle; retired increments by 1 on that edge, wrapping 0xFFFFFFFF->0.
REQ-019 Leaving W: halt_req=1 -> HALTED (phase=0); else run=0 -> IDLE (phase=0); else F. halt_req has priority over run=0.
REQ-020 run=0 in any phase other than W SHALL NOT interrupt the instruction; it is acted on only when leaving W.
REQ-021 HALTED: phase=0, mem_req=0; go to IDLE when run=0; stay HALTED while run=1.
REQ-022 Wait counter, 8 bits: cleared on every phase advance and whenever mem_req=0; increments each cycle with mem_req=1 and mem_ack=0.
REQ-023 Timeout: wait counter=255 with mem_req=1 and mem_ack=0 -> next state ERROR, phase=0, err=1; mem_ack=1 in that same cycle wins (normal advance, no error).
REQ-024 ERROR: sticky; phase=0, mem_req=0, retired frozen; left only by reset.
REQ-025 mem_req SHALL be 0 in IDLE, HALTED, ERROR, R, X, W and in M with mem_acc_m=0.
REQ-026 Minimum instruction latency: 5 cycles F..W with mem_ack=1 on the first F cycle and no M access; each stall cycle adds exactly 1.
REQ-027 Leaving W, the phase change to F occurs on the same edge the downstream program counter captures its next value.

Reset
REQ-028 n_rst=0 at an edge: state=IDLE, phase=0, mem_req=0, running=0, halted=0, err=0, retired=0, wait counter=0, from any state and any phase.
REQ-029 Reset mid-instruction: no W phase emitted and retired not incremented; after release, requires run=1 to restart at F.

Verification
REQ-030 Reset release, run=1, mem_ack=1 constant, mem_acc_m=0 -> phase 00001,00010,00100,01000,10000 repeating; retired=1 after first W, 2 after second.
REQ-031 mem_ack delayed 3 cycles in F, mem_acc_m=1 with ack delayed 2 cycles in M -> F held 4 cycles, M held 3; instruction takes 10 cycles; mem_req high exactly during F and M.
REQ-032 halt_req=1 during W -> next cycle phase=0, halted=1; run dropped to 0 -> IDLE; run=1 again -> F.
REQ-033 run dropped to 0 during X -> M and W still complete, retired increments, then IDLE with phase=0.
REQ-034 mem_ack held 0 in F -> err=1 after 256 stall cycles, phase=0, mem_req=0; ack arriving on cycle 256 instead -> advances to R, err stays 0.
REQ-035 retired preloaded to 0xFFFFFFFF by running to wrap, then one W -> retired=0; n_rst=0 asserted during M -> all outputs at reset values next cycle.
